exe_stage_md: RTL and testbench
===============================

# exe_stage_md

Parametrised execute stage for the 5-stage in-order core: ALU execution plus an in-stage multi-cycle multiply/divide unit, byte-lane store generation and a request/address-ok data-SRAM handshake. It sits between the ID and MEM stages and uses the standard valid/allowin pipeline protocol. It stalls itself (ready_go low) while a multiply, divide or memory request is outstanding, and it publishes a forwarding bundle with a busy flag so ID can interlock.

## Interface
- XLEN, 32: datapath width (32 or 64); data SRAM width = XLEN, byte enables = XLEN/8.
- MUL_LAT, 2: multiply occupancy in cycles, 1..4 (1 = combinational).
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- exe_flush  in  1  kill instruction in EXE, abort MD unit
- id_to_exe_valid  in  1  ID has an instruction
- exe_allowin  out  1  EXE can accept
- id_pc  in  32  instruction PC
- id_alu_op  in  12  op to existing combinational alu
- id_src1, id_src2  in  XLEN  operands (ALU and MD)
- id_md_op  in  3  000 none, 001 mul, 010 mulh, 011 mulhu, 100 div, 101 mod, 110 divu, 111 modu
- id_mem_op  in  4  {load, store, size[1:0]}; size 00 byte, 01 half, 10 word, 11 XLEN-wide
- id_ld_unsigned  in  1  zero-extend load (passed through)
- id_st_data  in  XLEN  store data
- id_rf_we, id_rf_waddr  in  1, 5  register write
- mem_allowin  in  1  MEM can accept
- exe_to_mem_valid  out  1
- exe_to_mem_zip  out  XLEN+43  {mem_op, ld_unsigned, rf_we, rf_waddr, result, pc}
- data_sram_req  out  1; data_sram_wr  out  1; data_sram_we  out  XLEN/8; data_sram_addr  out  XLEN; data_sram_wdata  out  XLEN
- data_sram_addr_ok  in  1  request accepted this cycle
- exe_rf_zip  out  XLEN+8  {busy, res_from_mem, rf_we, rf_waddr, result}

## Operation
- Capture all id_* fields when id_to_exe_valid & exe_allowin & ~exe_flush. Fields hold otherwise.
- exe_valid is set next cycle on capture. It clears on resetn low or exe_flush, or when the instruction leaves without a new capture.
- exe_allowin = ~exe_valid | (ready_go & mem_allowin); forced 1 during exe_flush. No capture occurs during flush.
- result: MD result if md_op≠0, else alu_result. Address = alu_result.
- If md_op≠0 and mem_op≠0, MD takes precedence and no memory request is issued.
- MUL: full 2·XLEN product; signed×signed for mul/mulh, unsigned for mulhu. mul returns the low half, mulh/mulhu the high half. A cycle counter runs 0..MUL_LAT-1.
- DIV: restoring, one quotient bit per cycle, on operand magnitudes. Signs are fixed up on completion: quotient negative iff signs differ, remainder takes the dividend's sign.
- Divide by zero: quotient all-ones, remainder = dividend. MIN_INT/-1 (signed): quotient MIN_INT, remainder 0.
- MD FSM: IDLE -> BUSY (on capture with md_op≠0) -> DONE (result latched) -> IDLE (when the instruction leaves or is flushed).
- DONE holds the result under backpressure; there is no recompute.
- Store byte enables: base mask (size 00:1, 01:2 bytes, 10:4, 11:all) shifted left by addr[log2(XLEN/8)-1:0] and truncated. Alignment is ID's responsibility.
- Store wdata: low 2^size bytes of st_data replicated across the bus.
- Memory request: data_sram_req = exe_valid & (load|store) & md_op==0 & ~req_done & ~exe_flush. data_sram_wr = store.
- req_done is set on req & addr_ok and cleared when the instruction leaves or is flushed.
- Address, we and wdata stay stable while req is high.
- ready_go: md_op≠0 requires MD DONE, or the final count in the same cycle. Memory ops require addr_ok this cycle or req_done. Otherwise ready_go = 1.
- exe_to_mem_valid = exe_valid & ready_go & ~exe_flush.
- busy = exe_valid & md_op≠0 & ~ready_go.
- exe_rf_zip write/res_from_mem bits are gated by exe_valid.

## Timing
- E = first cycle with exe_valid high for an instruction.
- ALU ops: ready_go in E.
- MUL: ready_go in E+MUL_LAT-1.
- DIV: operand load in E, iterations through E+XLEN, ready_go in E+XLEN (occupancy XLEN+1 cycles).
- Memory op: ready_go in the first cycle with addr_ok. The earliest is E.
- Reset values: exe_valid 0, exe_allowin 1, exe_to_mem_valid 0, data_sram_req 0, data_sram_we 0, busy 0, req_done 0, MD FSM IDLE.
- Flush mid-divide: FSM returns to IDLE next cycle. The next instruction starts with a fresh count.
- Flush and addr_ok cannot both be high for one request, because req is gated by flush.
- Back-to-back divides: the second captures in the same cycle the first leaves. It restarts the count.

## Test plan
- MUL_LAT=2, src1=0xFFFFFFFF, src2=2 -> mul 0xFFFFFFFE, mulhu 0x00000001, mulh 0xFFFFFFFF; exe_to_mem_valid at E+1; busy only in E.
- div -7/2 -> 0xFFFFFFFD, mod -> 0xFFFFFFFF; ready_go exactly E+32; busy high E..E+31.
- divu 5/0 -> 0xFFFFFFFF, modu 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000, mod -> 0.
- Store byte at addr 0x1003, st_data 0xAB, addr_ok low 3 cycles -> req held 4 cycles, we 4'b1000, wdata 0xABABABAB stable; exe_to_mem_valid only with addr_ok; exactly one accepted request.
- Divide finishes with mem_allowin low 5 cycles -> result stable, no second request, exe_allowin low until release.
- exe_flush at E+10 of a divide -> exe_valid 0 at E+11, no to_mem_valid; a following divu 100/7 returns 14 at full latency.

Source files
------------

// File: rtl/exe_stage_md.sv
`default_nettype none
// ============================================================================
//  Module   : exe_stage_md
//  Purpose  : Execute stage with ALU, iterative multiply/divide unit,
//             byte-lane store generation and data-SRAM req/addr_ok handshake.
//  Revision : 1.0  initial release
// ============================================================================
module exe_stage_md #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              exe_flush,
  input  logic              id_to_exe_valid,
  output logic              exe_allowin,
  input  logic [31:0]       id_pc,
  input  logic [11:0]       id_alu_op,
  input  logic [XLEN-1:0]   id_src1,
  input  logic [XLEN-1:0]   id_src2,
  input  logic [2:0]        id_md_op,
  input  logic [3:0]        id_mem_op,
  input  logic              id_ld_unsigned,
  input  logic [XLEN-1:0]   id_st_data,
  input  logic              id_rf_we,
  input  logic [4:0]        id_rf_waddr,
  input  logic              mem_allowin,
  output logic              exe_to_mem_valid,
  output logic [XLEN+42:0]  exe_to_mem_zip,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [XLEN/8-1:0] data_sram_we,
  output logic [XLEN-1:0]   data_sram_addr,
  output logic [XLEN-1:0]   data_sram_wdata,
  input  logic              data_sram_addr_ok,
  output logic [XLEN+7:0]   exe_rf_zip
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN);

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  logic              exe_valid, ready_go, capture, leave;
  logic [31:0]       pc;
  logic [11:0]       alu_op;
  logic [XLEN-1:0]   src1, src2, st_data;
  logic [2:0]        md_op;
  logic [3:0]        mem_op;
  logic              ld_unsigned, rf_we;
  logic [4:0]        rf_waddr;
  logic [XLEN-1:0]   alu_result, result;

  assign capture     = id_to_exe_valid & exe_allowin & ~exe_flush;
  assign leave       = exe_valid & ready_go & mem_allowin;
  assign exe_allowin = exe_flush | ~exe_valid | (ready_go & mem_allowin);

  // Pipeline valid bit: loads on handshake, dropped by flush
  always_ff @(posedge clk) begin
    if (!resetn || exe_flush) exe_valid <= 1'b0;
    else if (exe_allowin)     exe_valid <= id_to_exe_valid;
  end

  // Instruction fields; control fields reset so idle outputs are clean
  always_ff @(posedge clk) begin
    if (!resetn) begin
      md_op <= 3'd0; mem_op <= 4'd0; rf_we <= 1'b0;
    end else if (capture) begin
      pc <= id_pc; alu_op <= id_alu_op; src1 <= id_src1; src2 <= id_src2;
      md_op <= id_md_op; mem_op <= id_mem_op; ld_unsigned <= id_ld_unsigned;
      st_data <= id_st_data; rf_we <= id_rf_we; rf_waddr <= id_rf_waddr;
    end
  end

  // ---------------- ALU (one-hot op select) ----------------
  logic [SH_W-1:0] sh;
  logic [XLEN-1:0] sra_res;
  assign sh      = src2[SH_W-1:0];
  assign sra_res = $signed(src1) >>> sh;
  assign alu_result =
      ({XLEN{alu_op[0]}}  & (src1 + src2))
    | ({XLEN{alu_op[1]}}  & (src1 - src2))
    | ({XLEN{alu_op[2]}}  & {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)})
    | ({XLEN{alu_op[3]}}  & {{(XLEN-1){1'b0}}, src1 < src2})
    | ({XLEN{alu_op[4]}}  & (src1 & src2))
    | ({XLEN{alu_op[5]}}  & ~(src1 | src2))
    | ({XLEN{alu_op[6]}}  & (src1 | src2))
    | ({XLEN{alu_op[7]}}  & (src1 ^ src2))
    | ({XLEN{alu_op[8]}}  & (src1 << sh))
    | ({XLEN{alu_op[9]}}  & (src1 >> sh))
    | ({XLEN{alu_op[10]}} & sra_res)
    | ({XLEN{alu_op[11]}} & src2);

  // ---------------- Multiply: full-width product ----------------
  logic              mul_signed;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]   mul_res;
  assign mul_signed = (md_op != 3'b011);
  assign mul_a   = {{XLEN{mul_signed & src1[XLEN-1]}}, src1};
  assign mul_b   = {{XLEN{mul_signed & src2[XLEN-1]}}, src2};
  assign prod    = mul_a * mul_b;
  assign mul_res = (md_op == 3'b001) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // ---------------- Divide: restoring, one bit per cycle ----------------
  logic [XLEN-1:0] div_rem, div_quo, div_dsr, rem_nx, quo_nx, quo_fix, rem_fix, div_res;
  logic [XLEN:0]   trial;
  logic            s1_neg, s2_neg, step_ok;
  assign s1_neg  = ~md_op[1] & src1[XLEN-1];
  assign s2_neg  = ~md_op[1] & src2[XLEN-1];
  assign trial   = {div_rem, div_quo[XLEN-1]} - {1'b0, div_dsr};
  assign step_ok = ~trial[XLEN];
  assign rem_nx  = step_ok ? trial[XLEN-1:0] : {div_rem[XLEN-2:0], div_quo[XLEN-1]};
  assign quo_nx  = {div_quo[XLEN-2:0], step_ok};
  assign quo_fix = (s1_neg ^ s2_neg) ? -quo_nx : quo_nx;
  assign rem_fix = s1_neg ? -rem_nx : rem_nx;
  // Zero divisor bypasses the iteration result entirely
  assign div_res = (src2 == '0) ? (md_op[0] ? src1 : '1)
                                : (md_op[0] ? rem_fix : quo_fix);

  // ---------------- MD control FSM ----------------
  logic [1:0]       md_state;
  logic [CNT_W-1:0] md_cnt;
  logic [XLEN-1:0]  md_hold, md_now, md_out;
  logic             md_fin, md_ready, md_none;
  assign md_none  = (md_op == 3'd0);
  assign md_now   = md_op[2] ? div_res : mul_res;
  assign md_fin   = (md_state == MD_BUSY) & (md_cnt == (md_op[2] ? DIV_LAST : MUL_LAST));
  assign md_ready = (md_state == MD_DONE) | md_fin;
  assign md_out   = (md_state == MD_DONE) ? md_hold : md_now;

  // Sequencing: start on capture, count while busy, hold result until leave
  always_ff @(posedge clk) begin
    if (!resetn || exe_flush) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else if (capture && id_md_op != 3'd0) begin
      md_state <= MD_BUSY;
      md_cnt   <= '0;
    end else if (leave) begin
      md_state <= MD_IDLE;
    end else if (md_state == MD_BUSY) begin
      if (md_fin) begin
        md_state <= MD_DONE;
        md_hold  <= md_now;
      end else begin
        md_cnt <= md_cnt + 1'b1;
      end
    end
  end

  // Divider datapath: magnitudes loaded in the first busy cycle, then iterate
  always_ff @(posedge clk) begin
    if (md_state == MD_BUSY) begin
      if (md_cnt == '0) begin
        div_rem <= '0;
        div_quo <= s1_neg ? -src1 : src1;
        div_dsr <= s2_neg ? -src2 : src2;
      end else begin
        div_rem <= rem_nx;
        div_quo <= quo_nx;
      end
    end
  end

  // ---------------- Memory request ----------------
  logic            is_load, is_store, req_done;
  logic [NB-1:0]   base_mask;
  logic [XLEN-1:0] wdata_rep;
  assign is_load  = mem_op[3];
  assign is_store = mem_op[2];
  assign data_sram_req = exe_valid & (is_load | is_store) & md_none & ~req_done & ~exe_flush;

  // Accepted-request flag so the request is issued only once per instruction
  always_ff @(posedge clk) begin
    if (!resetn || exe_flush || leave)        req_done <= 1'b0;
    else if (data_sram_req && data_sram_addr_ok) req_done <= 1'b1;
  end

  // Byte-lane mask and replicated store data by access size
  always_comb begin
    base_mask = '1;
    wdata_rep = st_data;
    case (mem_op[1:0])
      2'b00:   begin base_mask = NB'(1);  wdata_rep = {NB{st_data[7:0]}};        end
      2'b01:   begin base_mask = NB'(3);  wdata_rep = {(NB/2){st_data[15:0]}};   end
      2'b10:   begin base_mask = NB'(15); wdata_rep = {(NB/4){st_data[31:0]}};   end
      default: begin base_mask = '1;      wdata_rep = st_data;                   end
    endcase
  end

  assign data_sram_wr    = is_store;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = wdata_rep;
  assign data_sram_we    = (data_sram_req & is_store) ? (base_mask << alu_result[OFF_W-1:0]) : '0;

  // ---------------- Stage outputs ----------------
  assign ready_go = !md_none ? md_ready
                  : (is_load | is_store) ? ((data_sram_req & data_sram_addr_ok) | req_done)
                  : 1'b1;
  assign result           = md_none ? alu_result : md_out;
  assign exe_to_mem_valid = exe_valid & ready_go & ~exe_flush;
  // A memory op shadowed by an MD op is not forwarded as a memory access
  assign exe_to_mem_zip   = {(md_none ? mem_op : 4'd0), ld_unsigned, rf_we, rf_waddr, result, pc};
  assign exe_rf_zip       = {exe_valid & ~md_none & ~ready_go,
                             exe_valid & is_load & md_none,
                             exe_valid & rf_we, rf_waddr, result};

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_md.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exe_stage_md
//  Purpose  : Directed self-checking bench for exe_stage_md (XLEN=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_exe_stage_md;
  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  logic              clk = 1'b0, resetn = 1'b0, exe_flush = 1'b0, id_to_exe_valid = 1'b0;
  logic [31:0]       id_pc = '0;
  logic [11:0]       id_alu_op = '0;
  logic [XLEN-1:0]   id_src1 = '0, id_src2 = '0, id_st_data = '0;
  logic [2:0]        id_md_op = '0;
  logic [3:0]        id_mem_op = '0;
  logic              id_ld_unsigned = 1'b0, id_rf_we = 1'b0;
  logic [4:0]        id_rf_waddr = '0;
  logic              mem_allowin = 1'b1, data_sram_addr_ok = 1'b0;
  logic              exe_allowin, exe_to_mem_valid, data_sram_req, data_sram_wr;
  logic [XLEN+42:0]  exe_to_mem_zip;
  logic [XLEN/8-1:0] data_sram_we;
  logic [XLEN-1:0]   data_sram_addr, data_sram_wdata;
  logic [XLEN+7:0]   exe_rf_zip;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_result, rf_result;
  logic        busy, res_from_mem, rf_we_o;
  assign mem_result   = exe_to_mem_zip[XLEN+31:32];
  assign rf_result    = exe_rf_zip[31:0];
  assign busy         = exe_rf_zip[XLEN+7];
  assign res_from_mem = exe_rf_zip[XLEN+6];
  assign rf_we_o      = exe_rf_zip[XLEN+5];

  exe_stage_md #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .exe_flush(exe_flush),
    .id_to_exe_valid(id_to_exe_valid), .exe_allowin(exe_allowin),
    .id_pc(id_pc), .id_alu_op(id_alu_op), .id_src1(id_src1), .id_src2(id_src2),
    .id_md_op(id_md_op), .id_mem_op(id_mem_op), .id_ld_unsigned(id_ld_unsigned),
    .id_st_data(id_st_data), .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr),
    .mem_allowin(mem_allowin), .exe_to_mem_valid(exe_to_mem_valid),
    .exe_to_mem_zip(exe_to_mem_zip), .data_sram_req(data_sram_req),
    .data_sram_wr(data_sram_wr), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .exe_rf_zip(exe_rf_zip)
  );

  always #5 clk = ~clk;

  // Watchdog in case a wait loop is ever broken
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single cycle; returns at start of cycle E
  task automatic issue(input [11:0] aop, input [31:0] a, input [31:0] b,
                       input [2:0] md, input [3:0] mop, input [31:0] st);
    id_alu_op = aop; id_src1 = a; id_src2 = b; id_md_op = md; id_mem_op = mop;
    id_st_data = st; id_rf_we = 1'b1; id_rf_waddr = 5'd3; id_pc = 32'h0000_4000;
    id_to_exe_valid = 1'b1;
    @(posedge clk); #1;
    id_to_exe_valid = 1'b0;
  endtask

  // Run one MD op; off is the expected cycle offset from E of exe_to_mem_valid
  task automatic run_md(input string tag, input [2:0] md, input [31:0] a,
                        input [31:0] b, input [31:0] exp, input int off);
    int n;
    bit busy_ok;
    issue(12'd0, a, b, md, 4'd0, 32'd0);
    n = 0; busy_ok = 1'b1;
    while (n < 80) begin
      @(negedge clk);
      if (exe_to_mem_valid) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      n++;
      @(posedge clk); #1;
    end
    chk({tag, " latency"}, n, off);
    chk({tag, " result"}, mem_result, exp);
    chk({tag, " rf result"}, rf_result, exp);
    chk({tag, " busy while running"}, busy_ok, 1'b1);
    chk({tag, " busy at done"}, busy, 1'b0);
    chk({tag, " rf_we"}, rf_we_o, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, reqcnt, acc, tmv;
    bit stable_ok, tmv_bad, reqseen, hold_ok;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst allowin", exe_allowin, 1'b1);
    chk("rst to_mem_valid", exe_to_mem_valid, 1'b0);
    chk("rst req", data_sram_req, 1'b0);
    chk("rst we", data_sram_we, 4'b0000);
    chk("rst busy", busy, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("post-rst allowin", exe_allowin, 1'b1);
    @(posedge clk); #1;

    // Multiply family
    run_md("mul",   3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, MUL_LAT - 1);
    run_md("mulhu", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, MUL_LAT - 1);
    run_md("mulh",  3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT - 1);

    // Divide family and corner cases
    run_md("div -7/2",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    run_md("mod -7/2",    3'b101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    run_md("divu 5/0",    3'b110, 32'd5, 32'd0, 32'hFFFF_FFFF, 32);
    run_md("modu 5/0",    3'b111, 32'd5, 32'd0, 32'd5, 32);
    run_md("div min/-1",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32);
    run_md("mod min/-1",  3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32);

    // Store byte to 0x1003, addr_ok withheld for three cycles
    issue(12'h001, 32'h0000_1000, 32'd3, 3'd0, 4'b0100, 32'h0000_00AB);
    reqcnt = 0; acc = 0; tmv = 0; stable_ok = 1'b1; tmv_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_sram_addr_ok = (i == 3);
      @(negedge clk);
      if (data_sram_req) begin
        reqcnt++;
        if (data_sram_we !== 4'b1000 || data_sram_wdata !== 32'hABAB_ABAB ||
            data_sram_addr !== 32'h0000_1003 || data_sram_wr !== 1'b1) stable_ok = 1'b0;
      end
      if (data_sram_req && data_sram_addr_ok) acc++;
      if (exe_to_mem_valid) begin
        tmv++;
        if (!(data_sram_req && data_sram_addr_ok)) tmv_bad = 1'b1;
      end
      @(posedge clk); #1;
    end
    data_sram_addr_ok = 1'b0;
    chk("store req cycles", reqcnt, 4);
    chk("store addr/we/wdata stable", stable_ok, 1'b1);
    chk("store accepted requests", acc, 1);
    chk("store to_mem_valid count", tmv, 1);
    chk("store to_mem_valid without addr_ok", tmv_bad, 1'b0);
    @(negedge clk);
    chk("idle we", data_sram_we, 4'b0000);
    @(posedge clk); #1;

    // Load word with addr_ok in E
    issue(12'h001, 32'h0000_2000, 32'd4, 3'd0, 4'b1010, 32'd0);
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    chk("load req in E", data_sram_req, 1'b1);
    chk("load wr", data_sram_wr, 1'b0);
    chk("load we", data_sram_we, 4'b0000);
    chk("load addr", data_sram_addr, 32'h0000_2004);
    chk("load to_mem_valid in E", exe_to_mem_valid, 1'b1);
    chk("load res_from_mem", res_from_mem, 1'b1);
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0;
    @(negedge clk);
    chk("load req after leave", data_sram_req, 1'b0);
    chk("load to_mem_valid after leave", exe_to_mem_valid, 1'b0);
    @(posedge clk); #1;

    // Divide (with shadowed load) under MEM backpressure
    mem_allowin = 1'b0;
    issue(12'd0, 32'hFFFF_FFF9, 32'd2, 3'b100, 4'b1010, 32'd0);
    n = 0; reqseen = 1'b0;
    while (n < 80) begin
      @(negedge clk);
      if (data_sram_req) reqseen = 1'b1;
      if (exe_to_mem_valid) break;
      n++;
      @(posedge clk); #1;
    end
    chk("bp latency", n, 32);
    hold_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (data_sram_req) reqseen = 1'b1;
      if (!(exe_to_mem_valid === 1'b1 && mem_result === 32'hFFFF_FFFD &&
            exe_allowin === 1'b0 && busy === 1'b0)) hold_ok = 1'b0;
    end
    chk("bp result held", hold_ok, 1'b1);
    chk("bp no memory request", reqseen, 1'b0);
    @(posedge clk); #1;
    mem_allowin = 1'b1;
    @(negedge clk);
    chk("bp release valid", exe_to_mem_valid, 1'b1);
    chk("bp release allowin", exe_allowin, 1'b1);
    chk("bp release result", mem_result, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp after leave", exe_to_mem_valid, 1'b0);
    @(posedge clk); #1;

    // Flush at E+10 of a divide, with an ALU op offered during the flush
    issue(12'd0, 32'd1000, 32'd3, 3'b100, 4'd0, 32'd0);
    repeat (10) begin @(posedge clk); #1; end
    exe_flush = 1'b1;
    id_to_exe_valid = 1'b1; id_alu_op = 12'h001; id_md_op = 3'd0; id_mem_op = 4'd0;
    id_src1 = 32'd1; id_src2 = 32'd1;
    @(negedge clk);
    chk("flush to_mem_valid", exe_to_mem_valid, 1'b0);
    chk("flush allowin", exe_allowin, 1'b1);
    @(posedge clk); #1;
    exe_flush = 1'b0; id_to_exe_valid = 1'b0;
    @(negedge clk);
    chk("post-flush no capture", exe_to_mem_valid, 1'b0);
    chk("post-flush busy", busy, 1'b0);
    chk("post-flush rf_we", rf_we_o, 1'b0);
    @(posedge clk); #1;
    run_md("divu 100/7", 3'b110, 32'd100, 32'd7, 32'd14, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
